dmem_arbiter: RTL and testbench

- Two-requester arbiter in front of the single-port Data_mem (CLK, A, WD, WE, RD).
- Requester 0 is the CPU load/store path; requester 1 is the program/data loader or debug port.
- One memory access per cycle, round-robin fairness, optional lock for back-to-back bursts bounded by a hold limit.
- Read data registered and returned with a valid strobe; misaligned word accesses rejected.

---
 rtl/dmem_arbiter.sv | 217 +++++++++++++++++++++
 tb/tb_dmem_arbiter.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-requester round-robin arbiter in front of a single-port
// data memory. Port 0 is the CPU load/store path, port 1 the loader/debug port.
// One access per cycle. ACK is same-cycle. An owner may keep the memory with
// LOCK, bounded by MAX_HOLD grants while the other port waits. Read data is
// registered and returned with a one-cycle RVALID. Misaligned word accesses
// never write memory and raise a one-cycle ERR.
module dmem_arbiter #(
    parameter int unsigned MAX_HOLD = 4,
    parameter int unsigned AW       = 32,
    parameter int unsigned DW       = 32
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          REQ0,
    input  logic          WE0,
    input  logic [AW-1:0] A0,
    input  logic [DW-1:0] WD0,
    input  logic          LOCK0,
    output logic          ACK0,
    output logic [DW-1:0] RD0,
    output logic          RVALID0,
    output logic          ERR0,
    input  logic          REQ1,
    input  logic          WE1,
    input  logic [AW-1:0] A1,
    input  logic [DW-1:0] WD1,
    input  logic          LOCK1,
    output logic          ACK1,
    output logic [DW-1:0] RD1,
    output logic          RVALID1,
    output logic          ERR1,
    output logic [AW-1:0] MEM_A,
    output logic [DW-1:0] MEM_WD,
    output logic          MEM_WE,
    input  logic [DW-1:0] MEM_RD
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } owner_e;

    localparam logic [3:0] MAX_HOLD_C = 4'(MAX_HOLD);

    owner_e        owner_q, owner_d;
    logic          last_q, last_d;      // port granted most recently
    logic          lock_q, lock_d;      // LOCK of the port granted last cycle
    logic [3:0]    hold_q, hold_d;      // consecutive held grants while contended
    logic [DW-1:0] rd0_q, rd0_d, rd1_q, rd1_d;
    logic          rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
    logic          err0_q, err0_d, err1_q, err1_d;

    logic          gnt0_s, gnt1_s;
    logic          stay0_s, stay1_s;
    logic          mis0_s, mis1_s;

    assign mis0_s = (A0[1:0] != 2'b00);
    assign mis1_s = (A1[1:0] != 2'b00);

    // Grant selection: honour a still-valid lock first, otherwise round-robin.
    always_comb begin
        gnt0_s  = 1'b0;
        gnt1_s  = 1'b0;
        stay0_s = (owner_q == OWN0) && REQ0 && lock_q && (!REQ1 || (hold_q < MAX_HOLD_C));
        stay1_s = (owner_q == OWN1) && REQ1 && lock_q && (!REQ0 || (hold_q < MAX_HOLD_C));
        if (RESET) begin
            gnt0_s = 1'b0;
            gnt1_s = 1'b0;
        end else if (stay0_s) begin
            gnt0_s = 1'b1;
        end else if (stay1_s) begin
            gnt1_s = 1'b1;
        end else if (REQ0 && REQ1) begin
            // Tie goes to the port that did not win last time.
            if (last_q) begin
                gnt0_s = 1'b1;
            end else begin
                gnt1_s = 1'b1;
            end
        end else if (REQ0) begin
            gnt0_s = 1'b1;
        end else if (REQ1) begin
            gnt1_s = 1'b1;
        end else begin
            gnt0_s = 1'b0;
            gnt1_s = 1'b0;
        end
    end

    // Memory-side mux; a misaligned access never reaches the write enable.
    always_comb begin
        ACK0   = gnt0_s;
        ACK1   = gnt1_s;
        MEM_A  = A0;
        MEM_WD = WD0;
        MEM_WE = 1'b0;
        if (gnt1_s) begin
            MEM_A  = A1;
            MEM_WD = WD1;
            MEM_WE = WE1 && !mis1_s;
        end else if (gnt0_s) begin
            MEM_WE = WE0 && !mis0_s;
        end else begin
            MEM_WE = 1'b0;
        end
    end

    // Next-state for ownership, round-robin pointer, lock and hold counter.
    always_comb begin
        owner_d = IDLE;
        last_d  = last_q;
        lock_d  = 1'b0;
        hold_d  = 4'd0;
        if (gnt0_s) begin
            owner_d = OWN0;
            last_d  = 1'b0;
            lock_d  = LOCK0;
            if ((owner_q == OWN0) && REQ1) begin
                hold_d = (hold_q < MAX_HOLD_C) ? (hold_q + 4'd1) : hold_q;
            end else begin
                hold_d = 4'd0;
            end
        end else if (gnt1_s) begin
            owner_d = OWN1;
            last_d  = 1'b1;
            lock_d  = LOCK1;
            if ((owner_q == OWN1) && REQ0) begin
                hold_d = (hold_q < MAX_HOLD_C) ? (hold_q + 4'd1) : hold_q;
            end else begin
                hold_d = 4'd0;
            end
        end else begin
            owner_d = IDLE;
            hold_d  = 4'd0;
        end
    end

    // Next-state for the per-port read data, RVALID and ERR pulses.
    always_comb begin
        rd0_d     = rd0_q;
        rd1_d     = rd1_q;
        rvalid0_d = 1'b0;
        rvalid1_d = 1'b0;
        err0_d    = 1'b0;
        err1_d    = 1'b0;
        if (gnt0_s) begin
            if (mis0_s) begin
                err0_d = 1'b1;
                if (!WE0) begin
                    rvalid0_d = 1'b1;
                    rd0_d     = '0;
                end else begin
                    rvalid0_d = 1'b0;
                end
            end else if (!WE0) begin
                rvalid0_d = 1'b1;
                rd0_d     = MEM_RD;
            end else begin
                rvalid0_d = 1'b0;
            end
        end else if (gnt1_s) begin
            if (mis1_s) begin
                err1_d = 1'b1;
                if (!WE1) begin
                    rvalid1_d = 1'b1;
                    rd1_d     = '0;
                end else begin
                    rvalid1_d = 1'b0;
                end
            end else if (!WE1) begin
                rvalid1_d = 1'b1;
                rd1_d     = MEM_RD;
            end else begin
                rvalid1_d = 1'b0;
            end
        end else begin
            rvalid0_d = 1'b0;
            rvalid1_d = 1'b0;
        end
    end

    // State register; reset clears ownership, favours port 0 and kills pulses.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            owner_q   <= IDLE;
            last_q    <= 1'b1;
            lock_q    <= 1'b0;
            hold_q    <= 4'd0;
            rd0_q     <= '0;
            rd1_q     <= '0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            err0_q    <= 1'b0;
            err1_q    <= 1'b0;
        end else begin
            owner_q   <= owner_d;
            last_q    <= last_d;
            lock_q    <= lock_d;
            hold_q    <= hold_d;
            rd0_q     <= rd0_d;
            rd1_q     <= rd1_d;
            rvalid0_q <= rvalid0_d;
            rvalid1_q <= rvalid1_d;
            err0_q    <= err0_d;
            err1_q    <= err1_d;
        end
    end

    assign RD0     = rd0_q;
    assign RD1     = rd1_q;
    assign RVALID0 = rvalid0_q;
    assign RVALID1 = rvalid1_q;
    assign ERR0    = err0_q;
    assign ERR1    = err1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: directed transactions, a small data memory
// stand-in, and a monitor that checks grants and read/error responses
// against queued expectations.
module tb_dmem_arbiter;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        REQ0, WE0, LOCK0, ACK0, RVALID0, ERR0;
    logic [31:0] A0, WD0, RD0;
    logic        REQ1, WE1, LOCK1, ACK1, RVALID1, ERR1;
    logic [31:0] A1, WD1, RD1;
    logic [31:0] MEM_A, MEM_WD, MEM_RD;
    logic        MEM_WE;
    logic        mem_load;

    logic [31:0] mem [0:15];

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    typedef struct {
        logic        rv;
        logic        err;
        logic [31:0] rd;
        int          due;
    } resp_t;

    resp_t rq0[$];
    resp_t rq1[$];
    int    gq[$];

    always #5 CLK = ~CLK;

    dmem_arbiter #(.MAX_HOLD(4), .AW(32), .DW(32)) dut (
        .CLK(CLK), .RESET(RESET),
        .REQ0(REQ0), .WE0(WE0), .A0(A0), .WD0(WD0), .LOCK0(LOCK0),
        .ACK0(ACK0), .RD0(RD0), .RVALID0(RVALID0), .ERR0(ERR0),
        .REQ1(REQ1), .WE1(WE1), .A1(A1), .WD1(WD1), .LOCK1(LOCK1),
        .ACK1(ACK1), .RD1(RD1), .RVALID1(RVALID1), .ERR1(ERR1),
        .MEM_A(MEM_A), .MEM_WD(MEM_WD), .MEM_WE(MEM_WE), .MEM_RD(MEM_RD)
    );

    // Data memory stand-in: combinational read, write on the rising edge.
    assign MEM_RD = mem[MEM_A[5:2]];
    always @(posedge CLK) begin
        if (mem_load) begin
            for (int i = 0; i < 16; i++) mem[i] <= 32'd0;
            mem[1] <= 32'h12345678;
        end else if (MEM_WE) begin
            mem[MEM_A[5:2]] <= MEM_WD;
        end
    end

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // kind 1: aligned read, 2: misaligned write, 3: misaligned read
    task automatic push_resp(input int p, input int kind, input logic [31:0] rd);
        resp_t e;
        e.rv  = (kind != 2);
        e.err = (kind != 1);
        e.rd  = (kind == 3) ? 32'd0 : rd;
        e.due = cyc + 1;
        if (p == 0) rq0.push_back(e);
        else        rq1.push_back(e);
    endtask

    // One requester transaction: hold request until ACK, then release.
    task automatic xfer(input int p, input logic we, input logic [31:0] a,
                        input logic [31:0] wd, input logic lock, input logic exp_we,
                        input int kind, input logic [31:0] exp_rd, input string name);
        int   n;
        logic ack;
        n   = 0;
        ack = 1'b0;
        if (p == 0) begin
            REQ0 = 1'b1; WE0 = we; A0 = a; WD0 = wd; LOCK0 = lock;
        end else begin
            REQ1 = 1'b1; WE1 = we; A1 = a; WD1 = wd; LOCK1 = lock;
        end
        while (!ack && n < 40) begin
            #1;
            ack = (p == 0) ? ACK0 : ACK1;
            if (!ack) begin
                @(negedge CLK);
                n++;
            end
        end
        if (!ack) begin
            checks++;
            errors++;
            $display("FAIL %s: no ACK within 40 cycles", name);
        end else begin
            chk({name, " MEM_WE"}, {31'd0, MEM_WE}, {31'd0, exp_we});
            chk({name, " MEM_A"}, MEM_A, a);
            if (kind != 0) push_resp(p, kind, exp_rd);
        end
        @(negedge CLK);
        if (p == 0) begin
            REQ0 = 1'b0; LOCK0 = 1'b0;
        end else begin
            REQ1 = 1'b0; LOCK1 = 1'b0;
        end
    endtask

    task automatic mon_resp(input int p, input logic rv, input logic er, input logic [31:0] rd);
        resp_t e;
        int    sz;
        sz = (p == 0) ? rq0.size() : rq1.size();
        if (rv || er) begin
            checks++;
            if (sz == 0) begin
                errors++;
                $display("FAIL resp%0d: unexpected pulse rvalid=%b err=%b rd=%h", p, rv, er, rd);
            end else begin
                if (p == 0) e = rq0.pop_front();
                else        e = rq1.pop_front();
                if (rv !== e.rv || er !== e.err || (e.rv && rd !== e.rd) || cyc != e.due) begin
                    errors++;
                    $display("FAIL resp%0d: got rvalid=%b err=%b rd=%h cyc=%0d expected rvalid=%b err=%b rd=%h cyc=%0d",
                             p, rv, er, rd, cyc, e.rv, e.err, e.rd, e.due);
                end
            end
        end else if (sz > 0) begin
            e = (p == 0) ? rq0[0] : rq1[0];
            if (e.due <= cyc) begin
                if (p == 0) void'(rq0.pop_front());
                else        void'(rq1.pop_front());
                checks++;
                errors++;
                $display("FAIL resp%0d: missing pulse got none expected rvalid=%b err=%b rd=%h at cyc=%0d",
                         p, e.rv, e.err, e.rd, e.due);
            end
        end
    endtask

    // Monitor: sample mid low phase, compare grants and responses to the queues.
    initial begin
        int g;
        forever begin
            @(negedge CLK);
            #3;
            if (ACK0 || ACK1) begin
                checks++;
                if (gq.size() == 0) begin
                    errors++;
                    $display("FAIL grant: got ACK0=%b ACK1=%b expected no grant", ACK0, ACK1);
                end else begin
                    g = gq.pop_front();
                    if ((ACK0 && ACK1) || (ACK1 ? 1 : 0) != g) begin
                        errors++;
                        $display("FAIL grant: got ACK0=%b ACK1=%b expected port %0d", ACK0, ACK1, g);
                    end
                end
            end
            mon_resp(0, RVALID0, ERR0, RD0);
            mon_resp(1, RVALID1, ERR1, RD1);
        end
    end

    task automatic do_reset();
        RESET = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
        RESET = 1'b0;
    endtask

    initial begin
        RESET = 1'b1; mem_load = 1'b1;
        REQ0 = 1'b0; WE0 = 1'b0; A0 = 32'd0; WD0 = 32'd0; LOCK0 = 1'b0;
        REQ1 = 1'b0; WE1 = 1'b0; A1 = 32'd0; WD1 = 32'd0; LOCK1 = 1'b0;

        // Reset: requests are ignored, outputs cleared.
        @(negedge CLK);
        REQ0 = 1'b1; WE0 = 1'b1; REQ1 = 1'b1; WE1 = 1'b1;
        #1;
        chk("rst ACK0", {31'd0, ACK0}, 32'd0);
        chk("rst ACK1", {31'd0, ACK1}, 32'd0);
        chk("rst MEM_WE", {31'd0, MEM_WE}, 32'd0);
        @(negedge CLK);
        chk("rst RD0", RD0, 32'd0);
        chk("rst RD1", RD1, 32'd0);
        chk("rst pulses", {28'd0, RVALID0, RVALID1, ERR0, ERR1}, 32'd0);
        REQ0 = 1'b0; WE0 = 1'b0; REQ1 = 1'b0; WE1 = 1'b0;
        mem_load = 1'b0;
        RESET = 1'b0;

        // Single read from port 0.
        gq.push_back(0);
        xfer(0, 1'b0, 32'd4, 32'd0, 1'b0, 1'b0, 1, 32'h12345678, "t1 rd");
        #3;
        chk("t1 RVALID0", {31'd0, RVALID0}, 32'd1);
        chk("t1 RD0", RD0, 32'h12345678);
        repeat (2) @(negedge CLK);

        // Same-cycle contention after reset: port 0 write first, then port 1 read.
        do_reset();
        gq.push_back(0); gq.push_back(1);
        fork
            xfer(0, 1'b1, 32'd0, 32'hFFFFFFFF, 1'b0, 1'b1, 0, 32'd0, "t2 wr0");
            xfer(1, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1, 32'hFFFFFFFF, "t2 rd1");
        join
        repeat (2) @(negedge CLK);

        // Continuous requests without lock alternate grants.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            gq.push_back(0); gq.push_back(1);
        end
        fork
            repeat (4) xfer(0, 1'b0, 32'd4, 32'd0, 1'b0, 1'b0, 1, 32'h12345678, "t3 p0");
            repeat (4) xfer(1, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1, 32'hFFFFFFFF, "t3 p1");
        join
        repeat (2) @(negedge CLK);

        // Locked port-1 burst: 5 grants, one for port 0, then port 1 resumes.
        gq.push_back(0);
        xfer(0, 1'b0, 32'd4, 32'd0, 1'b0, 1'b0, 1, 32'h12345678, "t4 pre");
        for (int i = 0; i < 5; i++) gq.push_back(1);
        gq.push_back(0);
        for (int i = 0; i < 3; i++) gq.push_back(1);
        fork
            repeat (8) xfer(1, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1, 32'hFFFFFFFF, "t4 p1");
            xfer(0, 1'b0, 32'd4, 32'd0, 1'b0, 1'b0, 1, 32'h12345678, "t4 p0");
        join
        repeat (2) @(negedge CLK);

        // Misaligned accesses: no write, ERR pulse, misaligned read returns 0.
        gq.push_back(0); gq.push_back(0); gq.push_back(1);
        xfer(0, 1'b1, 32'd6, 32'hDEADBEEF, 1'b0, 1'b0, 2, 32'd0, "t5 miswr");
        xfer(0, 1'b0, 32'd4, 32'd0, 1'b0, 1'b0, 1, 32'h12345678, "t5 rd");
        xfer(1, 1'b0, 32'd2, 32'd0, 1'b0, 1'b0, 3, 32'd0, "t5 misrd");
        repeat (2) @(negedge CLK);

        // Reset in the middle of a locked port-1 write burst.
        gq.push_back(1);
        REQ1 = 1'b1; LOCK1 = 1'b1; WE1 = 1'b1; A1 = 32'd8; WD1 = 32'h11111111;
        #1;
        chk("t6 ACK1 pre", {31'd0, ACK1}, 32'd1);
        chk("t6 MEM_WE pre", {31'd0, MEM_WE}, 32'd1);
        @(negedge CLK);
        RESET = 1'b1; WD1 = 32'h22222222;
        REQ0 = 1'b1; WE0 = 1'b0; A0 = 32'd4;
        #1;
        chk("t6 rst ACK0", {31'd0, ACK0}, 32'd0);
        chk("t6 rst ACK1", {31'd0, ACK1}, 32'd0);
        chk("t6 rst MEM_WE", {31'd0, MEM_WE}, 32'd0);
        @(negedge CLK);
        RESET = 1'b0; WD1 = 32'hA5A5A5A5;
        gq.push_back(0);
        #1;
        chk("t6 first ACK0", {31'd0, ACK0}, 32'd1);
        push_resp(0, 1, 32'h12345678);
        @(negedge CLK);
        REQ0 = 1'b0;
        gq.push_back(1);
        #1;
        chk("t6 ACK1 post", {31'd0, ACK1}, 32'd1);
        chk("t6 MEM_WE post", {31'd0, MEM_WE}, 32'd1);
        @(negedge CLK);
        REQ1 = 1'b0; LOCK1 = 1'b0; WE1 = 1'b0;
        repeat (3) @(negedge CLK);
        chk("t6 mem[2]", mem[2], 32'hA5A5A5A5);

        // Every expected grant and response was consumed.
        chk("grant queue empty", 32'(gq.size()), 32'd0);
        chk("resp0 queue empty", 32'(rq0.size()), 32'd0);
        chk("resp1 queue empty", 32'(rq1.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
